histogram_ctrl: RTL

HISTOGRAM_CTRL -- requirements
Module: histogram_ctrl

---
 rtl/histogram_ctrl_pkg.sv | 26 ++
 rtl/hist_bin_ram.sv | 29 ++
 rtl/histogram_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/histogram_ctrl_pkg.sv
// Shared types and constants for the pixel histogram controller.
// Bin count and saturation value are derived from the instance widths.
package histogram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_DRAIN,
        ST_READOUT,
        ST_DONE
    } hist_state_e;

    localparam int unsigned HIST_DEF_DATA_WIDTH  = 8;
    localparam int unsigned HIST_DEF_COUNT_WIDTH = 16;
    localparam int unsigned HIST_DRAIN_CYCLES    = 2;

    function automatic int unsigned hist_bins(input int unsigned data_width);
        return 32'd1 << data_width;
    endfunction

    function automatic longint unsigned hist_sat(input int unsigned count_width);
        return (64'd1 << count_width) - 64'd1;
    endfunction

endpackage

// File: rtl/hist_bin_ram.sv
// Simple dual-port bin storage: one write port, one registered read port.
// Contents are not reset; the controller zeroes every bin before each frame.
module hist_bin_ram
    import histogram_ctrl_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH = HIST_DEF_DATA_WIDTH,
    parameter int unsigned C_WORD_WIDTH = HIST_DEF_COUNT_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [C_ADDR_WIDTH-1:0] waddr_i,
    input  logic [C_WORD_WIDTH-1:0] wdata_i,
    input  logic [C_ADDR_WIDTH-1:0] raddr_i,
    output logic [C_WORD_WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = hist_bins(C_ADDR_WIDTH);

    logic [C_WORD_WIDTH-1:0] mem [DEPTH];

    // A read of the address being written returns the old word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/histogram_ctrl.sv
// Frame histogram engine: clears bins, counts accepted pixels with a
// forwarded read-modify-write pipeline, then streams all bins out.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for start_i
// ST_CLEAR   | writing zero to bins 0..N-1, one per cycle
// ST_ACCUM   | accepting pixels (ready_o=1) until a beat with last_i
// ST_DRAIN   | letting the final increment retire, priming read of bin 0
// ST_READOUT | presenting bins 0..N-1 on the valid/ready output
// ST_DONE    | one-cycle completion pulse
module histogram_ctrl
    import histogram_ctrl_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH  = HIST_DEF_DATA_WIDTH,
    parameter int unsigned C_COUNT_WIDTH = HIST_DEF_COUNT_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [C_DATA_WIDTH-1:0]  data_i,
    input  logic                     last_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [C_DATA_WIDTH-1:0]  bin_o,
    output logic [C_COUNT_WIDTH-1:0] count_o,
    output logic                     last_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     overflow_o
);

    localparam logic [C_DATA_WIDTH-1:0]  LAST_BIN = '1;
    localparam logic [C_COUNT_WIDTH-1:0] SAT      = C_COUNT_WIDTH'(hist_sat(C_COUNT_WIDTH));

    hist_state_e state_q, state_d;

    logic [C_DATA_WIDTH-1:0]  ptr_q;
    logic [1:0]               drain_q;
    logic                     s1_vld_q;
    logic [C_DATA_WIDTH-1:0]  s1_addr_q;
    logic                     wr_vld_q;
    logic [C_DATA_WIDTH-1:0]  wr_addr_q;
    logic [C_COUNT_WIDTH-1:0] wr_data_q;
    logic                     ovf_q;

    logic                     accept;
    logic                     rd_hs;
    logic [C_COUNT_WIDTH-1:0] base;
    logic                     sat_hit;
    logic [C_COUNT_WIDTH-1:0] inc_data;

    logic                     ram_we;
    logic [C_DATA_WIDTH-1:0]  ram_waddr;
    logic [C_COUNT_WIDTH-1:0] ram_wdata;
    logic [C_DATA_WIDTH-1:0]  ram_raddr;
    logic [C_COUNT_WIDTH-1:0] ram_rdata;

    assign accept = (state_q == ST_ACCUM) && valid_i;
    assign rd_hs  = (state_q == ST_READOUT) && ready_i;

    // The previous cycle's write has not reached the RAM read data yet.
    assign base     = (wr_vld_q && (wr_addr_q == s1_addr_q)) ? wr_data_q : ram_rdata;
    assign sat_hit  = (base == SAT);
    assign inc_data = sat_hit ? SAT : base + C_COUNT_WIDTH'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        busy_o  = 1'b1;
        done_o  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (ptr_q == LAST_BIN) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                ready_o = 1'b1;
                if (accept && last_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_q == 2'd0) begin
                    state_d = ST_READOUT;
                end
            end
            ST_READOUT: begin
                valid_o = 1'b1;
                if (rd_hs && (ptr_q == LAST_BIN)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Readout re-reads the presented bin while stalled, so count_o is held
    // without a separate skid register.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = ptr_q;
        ram_wdata = '0;
        if (state_q == ST_CLEAR) begin
            ram_we = 1'b1;
        end else if (s1_vld_q) begin
            ram_we    = 1'b1;
            ram_waddr = s1_addr_q;
            ram_wdata = inc_data;
        end
        if (state_q == ST_ACCUM) begin
            ram_raddr = data_i;
        end else if (rd_hs) begin
            ram_raddr = ptr_q + C_DATA_WIDTH'(1);
        end else begin
            ram_raddr = ptr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q     <= '0;
            drain_q   <= '0;
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if ((state_q == ST_CLEAR) || rd_hs) begin
                ptr_q <= ptr_q + C_DATA_WIDTH'(1);
            end
            if ((state_q == ST_ACCUM) && (state_d == ST_DRAIN)) begin
                drain_q <= 2'(HIST_DRAIN_CYCLES - 1);
            end else if (drain_q != 2'd0) begin
                drain_q <= drain_q - 2'd1;
            end
            s1_vld_q  <= accept;
            s1_addr_q <= data_i;
            wr_vld_q  <= s1_vld_q;
            wr_addr_q <= s1_addr_q;
            wr_data_q <= inc_data;
            if ((state_q == ST_IDLE) && start_i) begin
                ovf_q <= 1'b0;
            end else if (s1_vld_q && sat_hit) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bin_o      = valid_o ? ptr_q : '0;
    assign count_o    = valid_o ? ram_rdata : '0;
    assign last_o     = valid_o && (ptr_q == LAST_BIN);
    assign overflow_o = ovf_q;

    hist_bin_ram #(
        .C_ADDR_WIDTH (C_DATA_WIDTH),
        .C_WORD_WIDTH (C_COUNT_WIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

endmodule
